// File: rtl/riscv_defs.sv
// Shared RISC-V front-end definitions: fetch entry layout and the fault
// instruction substituted when the icache reports an error.
package riscv_defs;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INST_FAULT_DEFAULT = 32'h0000_0053;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Power-of-two circular buffer holding fetched instructions until decode
// consumes them; flush empties it in one cycle.
module riscv_fetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is left unreset; an entry is only observed after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch front end: issues icache reads under a credit limit,
// buffers in-order responses and discards responses made stale by a redirect.
module riscv_fetch_queue
    import riscv_defs::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] INST_FAULT      = INST_FAULT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_branch_i,
    input  logic [31:0] fetch_branch_pc_i,
    input  logic        fetch_accept_i,
    input  logic        fetch_invalidate_i,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic        icache_error_i,
    input  logic [31:0] icache_inst_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic        icache_flush_o,
    output logic        icache_invalidate_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             flush_q;
    logic [CNT_W-1:0] count;
    logic [31:0]      branch_pc;
    logic             credit_ok, req_accept, resp_valid, push, pop;

    fetch_entry_t               push_entry, head_entry;
    logic [FETCH_ENTRY_W-1:0]   head_bits;

    assign branch_pc  = {fetch_branch_pc_i[31:2], 2'b00};
    assign credit_ok  = ({1'b0, count} + {1'b0, out_q}) < DEPTH_C;
    assign icache_rd_o = !rst_i && !fetch_branch_i && (out_q < MAX_OUT_C) && credit_ok;
    assign req_accept = icache_rd_o && icache_accept_i;

    // A response with nothing outstanding is a leftover from before reset.
    assign resp_valid = icache_valid_i && (out_q != '0);
    assign push       = resp_valid && !fetch_branch_i && (drop_q == '0);
    assign pop        = fetch_valid_o && fetch_accept_i && !fetch_branch_i;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        drop_d    = drop_q;
        out_d     = out_q + CNT_W'(req_accept) - CNT_W'(resp_valid);
        if (fetch_branch_i) begin
            // Every request still in flight after this edge belongs to the old path.
            pc_d      = branch_pc;
            resp_pc_d = branch_pc;
            drop_d    = out_d;
        end else begin
            if (req_accept)                  pc_d      = pc_q + 32'd4;
            if (push)                        resp_pc_d = resp_pc_q + 32'd4;
            if (resp_valid && drop_q != '0)  drop_d    = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            flush_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            flush_q   <= fetch_invalidate_i;
        end
    end

    always_comb begin
        push_entry.pc    = resp_pc_q;
        push_entry.instr = icache_error_i ? INST_FAULT : icache_inst_i;
        push_entry.fault = icache_error_i;
    end

    riscv_fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (fetch_branch_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_bits),
        .count_o (count)
    );

    assign head_entry          = fetch_entry_t'(head_bits);
    assign fetch_valid_o       = (count != '0);
    assign fetch_pc_o          = head_entry.pc;
    assign fetch_instr_o       = head_entry.instr;
    assign fetch_fault_o       = head_entry.fault;
    assign icache_pc_o         = pc_q;
    assign icache_flush_o      = flush_q;
    assign icache_invalidate_o = 1'b0;

endmodule
